if_stage: RTL and testbench

//  Instruction-fetch stage directly upstream of the decode stage. Holds the PC and issues in-order

---
 rtl/if_stage.sv | 143 ++++++++++++++
 tb/tb_if_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage. Holds the fetch PC, issues in-order requests
// to instruction memory under a credit limit, and buffers returned words with their
// PCs for decode. Redirects flush the buffer and drop in-flight responses.
// Optional build macro: IF_ALIGN_CHECK_EN (misaligned redirect produces one faulting
// nop entry with adef_o=1 and halts fetch until the next redirect).
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000,
  parameter int unsigned IB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_gnt_i,
  input  logic        inst_rvalid_i,
  input  logic [31:0] inst_rdata_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  input  logic        id_ready_i
`ifdef IF_ALIGN_CHECK_EN
  ,
  output logic        adef_o
`endif
);

  localparam int unsigned PW = $clog2(IB_DEPTH);
  localparam int unsigned CW = $clog2(IB_DEPTH) + 1;
  localparam int unsigned SW = CW + 1;
  localparam logic [31:0] NOP_INST = 32'h0340_0000;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] outst;
  logic [CW-1:0] drop;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [31:0]   pc_mem   [IB_DEPTH];
  logic [31:0]   inst_mem [IB_DEPTH];

  logic [31:0]   tgt;
  logic [SW-1:0] credit;
  logic          fetch_halt;
  logic          adef_push;
  logic          rsp_keep;
  logic          issue;
  logic          push;
  logic          pop;
  logic [31:0]   push_inst;

`ifdef IF_ALIGN_CHECK_EN
  logic misalign;
  logic halt;
  logic adef_pend;
  logic adef_mem [IB_DEPTH];

  assign misalign   = |branch_target_i[1:0];
  assign tgt        = branch_target_i;
  assign fetch_halt = halt;
  assign adef_push  = adef_pend && (outst == '0) && (drop == '0);
  assign adef_o     = valid_o ? adef_mem[head] : 1'b0;
`else
  logic unused_tgt_lo;

  assign unused_tgt_lo = ^branch_target_i[1:0];
  assign tgt           = {branch_target_i[31:2], 2'b00};
  assign fetch_halt    = 1'b0;
  assign adef_push     = 1'b0;
`endif

  // Credit check uses registered count/outst so a pop frees a slot only next cycle
  assign credit     = SW'(count) + SW'(outst);
  assign inst_req_o = rst && !branch_flag_i && !fetch_halt && (credit < SW'(IB_DEPTH));
  assign inst_addr_o = fetch_pc;
  assign issue      = inst_req_o && inst_gnt_i;

  assign rsp_keep   = inst_rvalid_i && (drop == '0);
  assign push       = !branch_flag_i && (rsp_keep || adef_push);
  assign push_inst  = adef_push ? NOP_INST : inst_rdata_i;
  assign pop        = valid_o && id_ready_i && !branch_flag_i;

  assign valid_o    = (count != '0);
  assign pc_o       = valid_o ? pc_mem[head]   : 32'h0;
  assign inst_o     = valid_o ? inst_mem[head] : 32'h0;

  // PC, counters and buffer pointers; redirect takes priority over issue/push/pop
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc  <= RESET_PC;
      resp_pc   <= RESET_PC;
      count     <= '0;
      outst     <= '0;
      drop      <= '0;
      head      <= '0;
      tail      <= '0;
`ifdef IF_ALIGN_CHECK_EN
      halt      <= 1'b0;
      adef_pend <= 1'b0;
`endif
    end else if (branch_flag_i) begin
      fetch_pc  <= tgt;
      resp_pc   <= tgt;
      count     <= '0;
      head      <= '0;
      tail      <= '0;
      outst     <= outst - CW'(inst_rvalid_i);
      drop      <= outst - CW'(inst_rvalid_i);
`ifdef IF_ALIGN_CHECK_EN
      halt      <= misalign;
      adef_pend <= misalign;
`endif
    end else begin
      if (issue) fetch_pc <= fetch_pc + 32'd4;
      outst <= outst + CW'(issue) - CW'(inst_rvalid_i);
      if (inst_rvalid_i && (drop != '0)) drop <= drop - CW'(1);
      if (push) begin
        tail    <= tail + PW'(1);
        resp_pc <= resp_pc + 32'd4;
      end
      if (pop) head <= head + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
`ifdef IF_ALIGN_CHECK_EN
      if (adef_push) adef_pend <= 1'b0;
`endif
    end
  end

  // Buffer storage write; contents are only observed through count-gated outputs
  always_ff @(posedge clk) begin
    if (rst && push) begin
      pc_mem[tail]   <= resp_pc;
      inst_mem[tail] <= push_inst;
`ifdef IF_ALIGN_CHECK_EN
      adef_mem[tail] <= adef_push;
`endif
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized scoreboard bench for if_stage with an in-order,
// variable-latency memory model and an expected decode-stream model.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h1c00_0000;
  localparam int unsigned IB_DEPTH = 4;
  localparam logic [31:0] NOP      = 32'h0340_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_gnt_i = 1'b0;
  logic        inst_rvalid_i = 1'b0;
  logic [31:0] inst_rdata_i = 32'h0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = 32'h0;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        id_ready_i = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
  logic        adef_o;
`endif

  if_stage #(.RESET_PC(RESET_PC), .IB_DEPTH(IB_DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .inst_req_o      (inst_req_o),
    .inst_addr_o     (inst_addr_o),
    .inst_gnt_i      (inst_gnt_i),
    .inst_rvalid_i   (inst_rvalid_i),
    .inst_rdata_i    (inst_rdata_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .valid_o         (valid_o),
    .pc_o            (pc_o),
    .inst_o          (inst_o),
    .id_ready_i      (id_ready_i)
`ifdef IF_ALIGN_CHECK_EN
    ,
    .adef_o          (adef_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] inst; logic adef; } exp_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  exp_t        sb[$];
  mreq_t       mq[$];
  exp_t        mon_e;
  logic [31:0] gen_pc = 32'h0;
  bit          gen_on = 1'b0;
  bit          halted = 1'b0;
  bit          after_flush = 1'b0;
  bit          after_rst = 1'b0;
  int          cyc = 0, last_due = 0;
  int          errors = 0, checks = 0, issues = 0, pops = 0;
  int          lat_min = 1, lat_max = 1;
  int          gnt_pct = 100, rdy_pct = 100, rsp_pct = 100;

  // Instruction memory contents as a fixed function of address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected decode stream restarts at a new PC after reset or redirect
  function automatic void restart(input logic [31:0] t);
    sb.delete();
    halted = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
    if (t[1:0] != 2'b00) begin
      sb.push_back('{pc: t, inst: NOP, adef: 1'b1});
      gen_on = 1'b0;
      halted = 1'b1;
      return;
    end
    gen_pc = t;
`else
    gen_pc = {t[31:2], 2'b00};
`endif
    gen_on = 1'b1;
  endfunction

  function automatic void topup();
    while (gen_on && sb.size() < 16) begin
      sb.push_back('{pc: gen_pc, inst: mem_word(gen_pc), adef: 1'b0});
      gen_pc = gen_pc + 32'd4;
    end
  endfunction

  // One clock cycle of stimulus plus the memory model
  task automatic step(input bit br, input logic [31:0] tgt, input bit rst_v);
    int d;
    @(negedge clk);
    cyc++;
    rst             = rst_v;
    branch_flag_i   = br;
    branch_target_i = tgt;
    inst_gnt_i      = (int'($urandom_range(99)) < gnt_pct);
    id_ready_i      = (int'($urandom_range(99)) < rdy_pct);
    inst_rvalid_i   = 1'b0;
    inst_rdata_i    = $urandom;
    if (mq.size() > 0 && mq[0].due <= cyc && int'($urandom_range(99)) < rsp_pct) begin
      inst_rvalid_i = 1'b1;
      inst_rdata_i  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end
    #1;
    if (after_flush) begin
      check("valid_after_flush", 32'(valid_o), 32'h0);
      after_flush = 1'b0;
    end
    if (after_rst) begin
      check("addr_after_reset", inst_addr_o, RESET_PC);
      after_rst = 1'b0;
    end
    if (!rst_v || br) check("req_blocked", 32'(inst_req_o), 32'h0);
    if (halted) check("req_halted", 32'(inst_req_o), 32'h0);
    if (rst_v && inst_req_o && inst_gnt_i) begin
      issues++;
      d = cyc + lat_min + int'($urandom_range(lat_max - lat_min));
      if (d < last_due) d = last_due;
      last_due = d;
      mq.push_back('{addr: inst_addr_o, due: d});
    end
    #2;
    if (!rst_v) begin
      mq.delete();
      last_due    = 0;
      restart(RESET_PC);
      after_flush = 1'b1;
      after_rst   = 1'b1;
    end else if (br) begin
      restart(tgt);
      after_flush = 1'b1;
    end
    topup();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1);
  endtask

  task automatic mode(input int g, input int r, input int s, input int lmin, input int lmax);
    gnt_pct = g; rdy_pct = r; rsp_pct = s; lat_min = lmin; lat_max = lmax;
  endtask

  // Monitor: compares each accepted head entry against the expected stream
  always begin
    @(negedge clk);
    #2;
    if (rst && !branch_flag_i && valid_o && id_ready_i) begin
      if (sb.size() == 0) begin
        check("unexpected_pop", pc_o, 32'hFFFF_FFFF);
      end else begin
        mon_e = sb.pop_front();
        pops++;
        check("pop_pc", pc_o, mon_e.pc);
        check("pop_inst", inst_o, mon_e.inst);
`ifdef IF_ALIGN_CHECK_EN
        check("pop_adef", 32'(adef_o), 32'(mon_e.adef));
`endif
      end
    end else if (rst && !valid_o) begin
      check("empty_pc_zero", pc_o, 32'h0);
      check("empty_inst_zero", inst_o, 32'h0);
    end
  end

  initial begin
    int p0, i0;
    logic [31:0] t;

    // Streaming: 1-cycle memory, always ready -> one instruction per cycle
    mode(100, 100, 100, 1, 1);
    step(1'b0, 32'h0, 1'b0);
    p0 = pops;
    run(20);
    check("stream_pops", 32'(pops - p0), 32'd18);

    // Stall: decode not ready -> exactly IB_DEPTH requests, then request drops
    step(1'b0, 32'h0, 1'b0);
    mode(100, 0, 100, 1, 1);
    i0 = issues;
    run(10);
    check("stall_issues", 32'(issues - i0), 32'(IB_DEPTH));
    check("stall_req_low", 32'(inst_req_o), 32'h0);
    check("stall_valid", 32'(valid_o), 32'h1);
    mode(100, 100, 100, 1, 1);
    run(12);

    // Redirect with two responses in flight under 3-cycle latency
    mode(100, 100, 100, 3, 3);
    step(1'b0, 32'h0, 1'b0);
    run(2);
    step(1'b1, 32'h1c00_0100, 1'b1);
    p0 = pops;
    run(15);
    check("redirect_progress", 32'(pops > p0), 32'h1);

    // Redirect coinciding with response and pop in steady stream
    mode(100, 100, 100, 1, 1);
    run(6);
    step(1'b1, 32'h1c00_0200, 1'b1);
    run(8);

    // Misaligned redirect target
    step(1'b1, 32'h1c00_0102, 1'b1);
    run(10);

    // Reset mid-stream with two requests in flight
    mode(100, 100, 100, 3, 3);
    step(1'b1, 32'h1c00_0300, 1'b1);
    run(2);
    step(1'b0, 32'h0, 1'b0);
    check("rst_valid_zero", 32'(valid_o), 32'h0);
    run(15);

    // Random traffic with redirects and occasional resets
    mode(70, 70, 75, 1, 4);
    p0 = pops;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) begin
        step(1'b0, 32'h0, 1'b0);
      end else if ($urandom_range(19) == 0) begin
        t = RESET_PC + 32'($urandom_range(511)) * 32'd4;
        if ($urandom_range(9) == 0) t = t + 32'd2;
        step(1'b1, t, 1'b1);
      end else begin
        step(1'b0, 32'h0, 1'b1);
      end
    end
    check("random_progress", 32'(pops - p0 >= 300), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
